// File: rtl/bin_morph_3x3_pkg.sv
// bin_morph_3x3_pkg: shared constants and the 3x3 binary morphology operator.
//   MODE_ERODE / MODE_DILATE : operator select values for bin_morph_3x3 MODE
//   IMG_H_DEF / IMG_V_DEF    : default active frame size
//   morph_op                 : AND (erode) or OR (dilate) over a 9-bit window
package bin_morph_3x3_pkg;

    localparam int MODE_ERODE  = 0;
    localparam int MODE_DILATE = 1;
    localparam int IMG_H_DEF   = 640;
    localparam int IMG_V_DEF   = 480;

    function automatic logic morph_op(input logic [8:0] win, input int mode);
        return (mode == MODE_DILATE) ? |win : &win;
    endfunction

endpackage

// File: rtl/bin_morph_3x3_altshift_taps.sv
// altshift_taps: 2-tap 1-bit line buffer, one line of RAM_Length per tap.
//   clk     : clock
//   shift   : shift enable (one pixel per strobe)
//   shiftin : incoming pixel
//   taps0x  : pixel shifted in RAM_Length strobes ago (one line old)
//   taps1x  : pixel shifted in 2*RAM_Length strobes ago (two lines old)
// Contents are deliberately not reset; consumers mask the first two rows.
module altshift_taps #(
    parameter int RAM_Length = 640
) (
    input  logic clk,
    input  logic shift,
    input  logic shiftin,
    output logic taps0x,
    output logic taps1x
);

    logic [2*RAM_Length-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (shift) sr_q <= {sr_q[2*RAM_Length-2:0], shiftin};
    end

    assign taps0x = sr_q[RAM_Length-1];
    assign taps1x = sr_q[2*RAM_Length-1];

endmodule

// File: rtl/bin_morph_3x3.sv
// bin_morph_3x3: streaming 3x3 binary erosion/dilation with 2-cycle latency.
//   clk, rst_n                        : clock, synchronous active-low reset
//   per_frame_vsync/href/clken        : input frame sync, line qualifier, pixel strobe
//   per_img_bit                       : input binary pixel
//   post_frame_vsync/href/clken       : input syncs delayed by 2 clk
//   post_img_bit                      : filtered pixel, 0 outside the valid window
module bin_morph_3x3
    import bin_morph_3x3_pkg::*;
#(
    parameter int IMG_H = IMG_H_DEF,
    parameter int IMG_V = IMG_V_DEF,
    parameter int MODE  = MODE_ERODE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_bit
);

    localparam int CW = $clog2(IMG_H);
    localparam int RW = $clog2(IMG_V);

    logic          tap0, tap1;
    logic [1:0]    vsync_q, href_q, clken_q;
    logic [8:0]    win_q, win_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d;
    logic          pix_q, pix_d;
    logic          href_fall, vsync_rise;

    altshift_taps #(.RAM_Length(IMG_H)) u_lb (
        .clk     (clk),
        .shift   (per_frame_clken),
        .shiftin (per_img_bit),
        .taps0x  (tap0),
        .taps1x  (tap1)
    );

    // Window rows are {top, mid, bottom} = bits {8:6, 5:3, 2:0}, oldest column in the MSB.
    always_comb begin
        href_fall  = href_q[0] & ~per_frame_href;
        vsync_rise = per_frame_vsync & ~vsync_q[0];
        col_d      = href_fall ? '0 :
                     (per_frame_clken && col_q != CW'(IMG_H-1)) ? col_q + CW'(1) : col_q;
        row_d      = vsync_rise ? '0 :
                     (href_fall && row_q != RW'(IMG_V-1)) ? row_q + RW'(1) : row_q;
        win_d      = per_frame_clken ?
                     {win_q[7:6], tap1, win_q[4:3], tap0, win_q[1:0], per_img_bit} : win_q;
        valid_d    = per_frame_clken ? (col_q >= CW'(2) && row_q >= RW'(2)) : valid_q;
        pix_d      = clken_q[0] & valid_q & morph_op(win_q, MODE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= '0;
            href_q  <= '0;
            clken_q <= '0;
            win_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            vsync_q <= {vsync_q[0], per_frame_vsync};
            href_q  <= {href_q[0], per_frame_href};
            clken_q <= {clken_q[0], per_frame_clken};
            win_q   <= win_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
        end
    end

    assign post_frame_vsync = vsync_q[1];
    assign post_frame_href  = href_q[1];
    assign post_frame_clken = clken_q[1];
    assign post_img_bit     = pix_q;

endmodule

// File: tb/tb_bin_morph_3x3.sv
// tb_bin_morph_3x3: erosion and dilation instances on shared frame stimulus, checked against an image-level model.
module tb_bin_morph_3x3;
    import bin_morph_3x3_pkg::*;

    localparam int H = 8;
    localparam int V = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b0, hr = 1'b0, ck = 1'b0, px = 1'b0;
    logic e_vs, e_hr, e_ck, e_px, d_vs, d_hr, d_ck, d_px;

    always #5 clk = ~clk;

    bin_morph_3x3 #(.IMG_H(H), .IMG_V(V), .MODE(MODE_ERODE)) u_ero (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_bit(px),
        .post_frame_vsync(e_vs), .post_frame_href(e_hr), .post_frame_clken(e_ck), .post_img_bit(e_px)
    );

    bin_morph_3x3 #(.IMG_H(H), .IMG_V(V), .MODE(MODE_DILATE)) u_dil (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_bit(px),
        .post_frame_vsync(d_vs), .post_frame_href(d_hr), .post_frame_clken(d_ck), .post_img_bit(d_px)
    );

    typedef struct {
        bit e;
        bit d;
        int x;
        int y;
    } exp_t;

    exp_t q[$];
    bit   img[V][H];
    bit   out_e[V][H], out_d[V][H], sav_e[V][H], sav_d[V][H];
    int   errors = 0, checks = 0;
    int   erow = 0, ecol = 0;
    logic [1:0] h_v = '0, h_h = '0, h_c = '0, h_r = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: AND/OR over the 3x3 image neighbourhood ending at (x,y).
    function automatic bit win_op(input int y, input int x, input int mode);
        bit a = 1'b1, o = 1'b0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                a &= img[y-2+dy][x-2+dx];
                o |= img[y-2+dy][x-2+dx];
            end
        return (mode == MODE_DILATE) ? o : a;
    endfunction

    function automatic int cnt_e();
        int n = 0;
        for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) n += int'(out_e[y][x]);
        return n;
    endfunction

    function automatic int cnt_d();
        int n = 0;
        for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) n += int'(out_d[y][x]);
        return n;
    endfunction

    // Latency of the sync outputs and per-pixel comparison against the queued model values.
    always @(posedge clk) begin
        h_v <= {h_v[0], vs};
        h_h <= {h_h[0], hr};
        h_c <= {h_c[0], ck};
        h_r <= {h_r[0], rst_n};
    end

    always @(negedge clk) begin
        logic ok;
        ok = h_r[0] & h_r[1];
        chk("vsync_dly", e_vs, h_v[1] & ok);
        chk("href_dly", e_hr, h_h[1] & ok);
        chk("clken_dly", e_ck, h_c[1] & ok);
        chk("dil_sync", {d_vs, d_hr, d_ck}, {e_vs, e_hr, e_ck});
        if (e_ck) begin
            if (q.size() == 0) chk("queue_underrun", 1, 0);
            else begin
                exp_t t;
                t = q.pop_front();
                chk("erode_px", e_px, t.e);
                chk("dilate_px", d_px, t.d);
                out_e[t.y][t.x] = e_px;
                out_d[t.y][t.x] = d_px;
            end
        end else begin
            chk("idle_erode", e_px, 0);
            chk("idle_dilate", d_px, 0);
        end
    end

    task automatic fill(input bit v);
        for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = v;
    endtask

    task automatic fill_rand(input int p1);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) img[y][x] = ($urandom_range(0, 3) < p1);
    endtask

    task automatic clr_out();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                out_e[y][x] = 1'b0;
                out_d[y][x] = 1'b0;
            end
    endtask

    task automatic px_drive(input int y, input int x);
        exp_t t;
        bit   v;
        v   = (erow >= 2) && (ecol >= 2);
        t.e = v ? win_op(y, x, MODE_ERODE) : 1'b0;
        t.d = v ? win_op(y, x, MODE_DILATE) : 1'b0;
        t.x = x;
        t.y = y;
        q.push_back(t);
        px = img[y][x];
        ck = 1'b1;
        if (ecol < H - 1) ecol++;
        tick();
        ck = 1'b0;
        px = 1'b0;
    endtask

    task automatic frame(input int gmin, input int gmax, input bit do_rst);
        clr_out();
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        erow = 0;
        ecol = 0;
        repeat (2) tick();
        for (int y = 0; y < V; y++) begin
            hr = 1'b1;
            for (int x = 0; x < H; x++) begin
                px_drive(y, x);
                repeat ($urandom_range(gmin, gmax)) tick();
                if (do_rst && y == 3 && x == 3) begin
                    tick();
                    rst_n = 1'b0;
                    tick();
                    chk("rst_zero", {e_vs, e_hr, e_ck, e_px, d_vs, d_hr, d_ck, d_px}, 0);
                    rst_n = 1'b1;
                    erow = 0;
                    ecol = 0;
                    tick();
                end
            end
            hr = 1'b0;
            if (erow < V - 1) erow++;
            ecol = 0;
            repeat (3) tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        repeat (4) tick();
        rst_n = 1'b1;
        tick();

        fill(1'b1);
        frame(0, 0, 1'b0);
        chk("f1_erode_count", cnt_e(), 24);
        chk("f1_erode_x2y2", out_e[2][2], 1);
        chk("f1_erode_y1", out_e[1][5], 0);
        chk("f1_erode_x1", out_e[4][1], 0);
        chk("f1_dilate_count", cnt_d(), 24);

        fill(1'b0);
        frame(0, 0, 1'b0);
        chk("f2_dilate_count", cnt_d(), 0);
        chk("f2_erode_count", cnt_e(), 0);

        fill(1'b0);
        img[3][4] = 1'b1;
        frame(0, 0, 1'b0);
        chk("f3_dilate_count", cnt_d(), 9);
        chk("f3_dilate_x4y3", out_d[3][4], 1);
        chk("f3_dilate_x6y5", out_d[5][6], 1);
        chk("f3_dilate_x4y2", out_d[2][4], 0);
        chk("f3_dilate_x7y3", out_d[3][7], 0);

        fill(1'b1);
        img[3][4] = 1'b0;
        frame(0, 0, 1'b0);
        chk("f4_erode_count", cnt_e(), 15);
        chk("f4_erode_x5y4", out_e[4][5], 0);
        chk("f4_erode_x4y2", out_e[2][4], 1);
        chk("f4_erode_x7y3", out_e[3][7], 1);

        fill_rand(3);
        frame(2, 2, 1'b0);
        sav_e = out_e;
        sav_d = out_d;
        frame(0, 0, 1'b0);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                chk("gap_equiv_erode", out_e[y][x], sav_e[y][x]);
                chk("gap_equiv_dilate", out_d[y][x], sav_d[y][x]);
            end

        fill_rand(2);
        frame(0, 2, 1'b1);

        fill(1'b1);
        frame(0, 1, 1'b0);
        chk("f8_erode_count", cnt_e(), 24);
        chk("f8_erode_x2y2", out_e[2][2], 1);
        chk("f8_erode_x1y5", out_e[5][1], 0);

        for (int f = 0; f < 4; f++) begin
            fill_rand(f[0] ? 3 : 1);
            frame(0, 2, 1'b0);
        end

        repeat (5) tick();
        chk("queue_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_morph_3x3.md
BIN_MORPH_3X3 -- requirements
Module: bin_morph_3x3

Interface
REQ-001 SHALL have parameter IMG_H, default 640: active pixels per line; also sets the line-buffer length.
REQ-002 SHALL have parameter IMG_V, default 480: active lines per frame.
REQ-003 SHALL have parameter MODE, default 0: 0 = erosion (AND of 9), 1 = dilation (OR of 9).
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port per_frame_vsync, input, 1: frame sync, high between frames.
REQ-007 SHALL have port per_frame_href, input, 1: line-active qualifier.
REQ-008 SHALL have port per_frame_clken, input, 1: pixel strobe, valid only while href is high.
REQ-009 SHALL have port per_img_bit, input, 1: binary motion-mask pixel.
REQ-010 SHALL have port post_frame_vsync, output, 1: per_frame_vsync delayed by 2 clk.
REQ-011 SHALL have port post_frame_href, output, 1: per_frame_href delayed by 2 clk.
REQ-012 SHALL have port post_frame_clken, output, 1: per_frame_clken delayed by 2 clk.
REQ-013 SHALL have port post_img_bit, output, 1: filtered pixel.

Function
REQ-014 SHALL shift per_img_bit into a 2-line 1-bit line buffer on every clken, producing tap0 (1 line old) and tap1 (2 lines old).
REQ-015 On each clken, the 3x3 window SHALL shift left one column, with new column {tap1, tap0, per_img_bit} as rows {top, mid, bottom}; registered at cycle N+1 after the clken at cycle N.
REQ-016 col_cnt (width clog2(IMG_H)) SHALL increment on each clken and clear on the href falling edge; it SHALL saturate at IMG_H-1, never wrap.
REQ-017 row_cnt (width clog2(IMG_V)) SHALL increment on each href falling edge, clear on the vsync rising edge, and saturate at IMG_V-1.
REQ-018 Window-valid SHALL be (col_cnt >= 2) AND (row_cnt >= 2), sampled with the stage-1 window.
REQ-019 Stage 2 (cycle N+2) SHALL register post_img_bit = MODE-op(9 bits) when window-valid, else 0.
REQ-020 Output pixel at position (x,y) SHALL represent the window centred at (x-1,y-1); the one-pixel spatial offset is accepted behaviour.
REQ-021 post_img_bit SHALL be 0 whenever post_frame_clken is 0.
REQ-022 Clken pulses SHALL be accepted back-to-back, every cycle, with no stall; there is no backpressure.
REQ-023 A line shorter than IMG_H SHALL end the line at the href falling edge without corrupting the counters; a longer line SHALL hold col_cnt at IMG_H-1.
REQ-024 Stale line-buffer contents from the previous frame SHALL never reach the output, because rows 0-1 are forced to 0 by REQ-018.
REQ-025 Vsync rising in mid-line SHALL clear row_cnt immediately; col_cnt SHALL clear at the next href fall.

Reset
REQ-026 While rst_n=0 at a clk edge, all post_* outputs, the delay registers, the window, col_cnt and row_cnt SHALL be 0 on the next cycle.
REQ-027 The line buffer SHALL NOT be reset; correctness after reset SHALL rely on REQ-018.
REQ-028 A reset applied mid-frame SHALL leave outputs 0 until a new line arrives; the first two rows after reset SHALL output 0.

Structure
REQ-029 A shared package SHALL hold the MODE_ERODE/MODE_DILATE constants and the default IMG_H/IMG_V.
REQ-030 The 2-tap 1-bit line buffer SHALL be a single sub-module, the team's existing altshift_taps, instantiated with RAM_Length = IMG_H and shift = per_frame_clken.
REQ-031 Counters, window, operator and sync delays SHALL reside in bin_morph_3x3 itself.

Verification
REQ-032 Scenario: IMG_H=8, IMG_V=6, MODE=0, all-ones frame -> post_img_bit=1 exactly for x>=2 and y>=2; 0 elsewhere.
REQ-033 Scenario: MODE=0, single 0 pixel at (4,3) in an all-ones frame -> zeros at x in 4..6, y in 3..5 (offset per REQ-020).
REQ-034 Scenario: MODE=1, single 1 pixel at (4,3) in an all-zero frame -> a 3x3 block of ones at x 4..6, y 3..5; all other pixels 0.
REQ-035 Scenario: clken every cycle vs. clken every 3rd cycle -> identical output bit sequence; post_frame_clken lags per_frame_clken by exactly 2 clk.
REQ-036 Scenario: rst_n pulsed low 1 cycle during row 3 -> all outputs 0 the next cycle; the next frame after vsync is bit-exact with REQ-032.
REQ-037 Scenario: two consecutive frames, first all-ones, second all-zeros, MODE=1 -> the second frame's output is all 0; no leakage from frame 1.
